// File: rtl/ape_dec_ctrl.sv
// APE decryption controller: sequences init beat, data beats and completion
// around an external combinational decryption core.
//
// Ports:
//   clk, error (async active-low reset), start, abort
//   key_i/tag/nblk        message parameters, latched on an accepted start
//   ct_valid/ct_ready/ct_data  ciphertext input stream
//   pt_valid/pt_ready/pt_data  plaintext output stream (registered)
//   core_*                drive / results of the external decryption core
//   busy, done, fin_vc    status and final Vc value
module ape_dec_ctrl #(
    parameter int RATE = 34,
    parameter int CAP  = 16,
    parameter int CW   = 8
) (
    input  logic            clk,
    input  logic            error,
    input  logic            start,
    input  logic            abort,
    input  logic [63:0]     key_i,
    input  logic [CAP-1:0]  tag,
    input  logic [CW-1:0]   nblk,
    input  logic            ct_valid,
    output logic            ct_ready,
    input  logic [RATE-1:0] ct_data,
    output logic            pt_valid,
    input  logic            pt_ready,
    output logic [RATE-1:0] pt_data,
    output logic            core_rst_n,
    output logic [63:0]     core_key,
    output logic [CAP-1:0]  core_tag,
    output logic [RATE-1:0] core_ctext,
    output logic [CAP-1:0]  core_vc,
    output logic [RATE-1:0] core_prev,
    input  logic [RATE-1:0] core_dout,
    input  logic [CAP-1:0]  core_vc_l,
    input  logic [RATE-1:0] core_prev_l,
    output logic            busy,
    output logic            done,
    output logic [CAP-1:0]  fin_vc
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [63:0]     key_r;
    logic [CAP-1:0]  tag_r;
    logic [CW-1:0]   cnt;
    logic [CAP-1:0]  vc_reg;
    logic [RATE-1:0] prev_reg;
    logic            ct_acc;
    logic            pt_hs;
    logic            finish;

    assign core_key   = key_r;
    assign core_tag   = tag_r;
    assign core_ctext = ct_data;
    assign core_vc    = vc_reg;
    assign core_prev  = prev_reg;
    assign busy       = (state != IDLE);
    assign core_rst_n = (state == RUN);

    // Abort masks ready so a simultaneous beat is never consumed.
    always_comb begin
        ct_ready = 1'b0;
        unique case (state)
            INIT:    ct_ready = !abort;
            RUN:     ct_ready = (!pt_valid || pt_ready) && !abort;
            default: ct_ready = 1'b0;
        endcase
    end

    assign ct_acc = ct_valid && ct_ready;
    assign pt_hs  = pt_valid && pt_ready;

    always_ff @(posedge clk or negedge error) begin
        if (!error) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        finish  = 1'b0;
        unique case (state)
            IDLE: if (start) state_n = INIT;
            INIT: if (ct_acc) state_n = (cnt == '0) ? DONE : RUN;
            RUN:  if (ct_acc && cnt == CW'(1)) state_n = DONE;
            DONE: begin
                if (!pt_valid) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge error) begin
        if (!error) begin
            key_r    <= '0;
            tag_r    <= '0;
            cnt      <= '0;
            vc_reg   <= '0;
            prev_reg <= '0;
            pt_valid <= 1'b0;
            pt_data  <= '0;
            done     <= 1'b0;
            fin_vc   <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                pt_valid <= 1'b0;
                cnt      <= '0;
            end else begin
                if (state == IDLE && start) begin
                    key_r <= key_i;
                    tag_r <= tag;
                    cnt   <= nblk;
                end
                if (ct_acc && state == INIT) begin
                    vc_reg   <= core_vc_l;
                    prev_reg <= core_prev_l;
                end
                // A new beat refills the buffer even while it drains.
                if (ct_acc && state == RUN) begin
                    pt_data  <= core_dout;
                    pt_valid <= 1'b1;
                    vc_reg   <= core_vc_l;
                    prev_reg <= ct_data;
                    cnt      <= cnt - CW'(1);
                end else if (pt_hs) begin
                    pt_valid <= 1'b0;
                end
                if (finish) begin
                    done   <= 1'b1;
                    fin_vc <= vc_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_ape_dec_ctrl.sv
// Self-checking bench for ape_dec_ctrl with a behavioural stand-in core.
// Table of messages plus hand sequences for init beat, abort and reset.
module tb_ape_dec_ctrl;

    localparam int RATE = 34;
    localparam int CAP  = 16;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            error = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [63:0]     key_i = '0;
    logic [CAP-1:0]  tag = '0;
    logic [CW-1:0]   nblk = '0;
    logic            ct_valid = 1'b0;
    logic            ct_ready;
    logic [RATE-1:0] ct_data = '0;
    logic            pt_valid;
    logic            pt_ready = 1'b0;
    logic [RATE-1:0] pt_data;
    logic            core_rst_n;
    logic [63:0]     core_key;
    logic [CAP-1:0]  core_tag;
    logic [RATE-1:0] core_ctext;
    logic [CAP-1:0]  core_vc;
    logic [RATE-1:0] core_prev;
    logic [RATE-1:0] core_dout;
    logic [CAP-1:0]  core_vc_l;
    logic [RATE-1:0] core_prev_l;
    logic            busy;
    logic            done;
    logic [CAP-1:0]  fin_vc;

    int n_chk  = 0;
    int n_fail = 0;

    ape_dec_ctrl #(.RATE(RATE), .CAP(CAP), .CW(CW)) dut (
        .clk(clk), .error(error), .start(start), .abort(abort),
        .key_i(key_i), .tag(tag), .nblk(nblk),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .core_rst_n(core_rst_n), .core_key(core_key), .core_tag(core_tag),
        .core_ctext(core_ctext), .core_vc(core_vc), .core_prev(core_prev),
        .core_dout(core_dout), .core_vc_l(core_vc_l),
        .core_prev_l(core_prev_l),
        .busy(busy), .done(done), .fin_vc(fin_vc)
    );

    always #5 clk = ~clk;

    function automatic logic [CAP-1:0] vcn(logic [CAP-1:0] v,
                                           logic [RATE-1:0] c);
        return {v[14:0], v[15]} ^ c[15:0] ^ c[33:18];
    endfunction

    function automatic logic [RATE-1:0] dec(logic [RATE-1:0] c,
                                            logic [RATE-1:0] p,
                                            logic [CAP-1:0] v);
        return c ^ p ^ {v[1:0], v, v};
    endfunction

    function automatic logic [RATE-1:0] gen(int seed, int i);
        logic [63:0] x;
        x = (64'(seed) + 64'd1) * 64'h9E37_79B9_7F4A_7C15
          + 64'(i) * 64'hBF58_476D_1CE4_E5B9;
        x = x ^ (x >> 29);
        return x[33:0] ^ x[63:30];
    endfunction

    // Stand-in for the decryption core.
    always_comb begin
        core_dout   = dec(core_ctext, core_prev, core_vc);
        core_prev_l = core_ctext;
        if (core_rst_n) core_vc_l = vcn(core_vc, core_ctext);
        else            core_vc_l = core_tag ^ core_key[15:0];
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] tag;
        logic [63:0] key;
        int          nblk;
        int          seed;
        bit          thr;
        bit          stall;
        int          abort_at;
        logic [15:0] exp_vc0;
        bit          cmp_prev;
    } vec_t;

    vec_t        tbl[7];
    logic [15:0] last_fin;

    task automatic run_msg(input vec_t v, output logic [CAP-1:0] fin);
        logic [RATE-1:0] ct[0:256];
        logic [RATE-1:0] ep[0:255];
        logic [CAP-1:0]  vc;
        logic [RATE-1:0] prev;
        logic [RATE-1:0] hold_pt;
        logic [CAP-1:0]  hold_vc;
        int n, ci, po, cyc, stall;
        bit seen, stalled, c0chk, aborted;
        n = v.nblk;
        for (int i = 0; i <= n; i++) ct[i] = gen(v.seed, i);
        vc   = v.tag ^ v.key[15:0];
        prev = ct[0];
        for (int i = 1; i <= n; i++) begin
            ep[i-1] = dec(ct[i], prev, vc);
            vc      = vcn(vc, ct[i]);
            prev    = ct[i];
        end
        fin = '0;
        @(negedge clk);
        start = 1'b1; key_i = v.key; tag = v.tag; nblk = CW'(n);
        @(negedge clk);
        start = 1'b0;
        ci = 0; po = 0; cyc = 0; stall = 0;
        seen = 0; stalled = 0; c0chk = 0; aborted = 0;
        while (!seen && !aborted && cyc < 4000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (c0chk) begin
                check("init_vc", core_vc, v.exp_vc0);
                c0chk = 0;
            end
            if (done) begin
                seen = 1;
                fin  = fin_vc;
                check("fin_vc", fin_vc, vc);
                check("pt_count", po, n);
            end else if (v.abort_at > 0 && po == v.abort_at) begin
                abort = 1'b1; ct_valid = 1'b1; ct_data = ct[ci];
                pt_ready = 1'b1;
                #1;
                check("abort_ct_ready", ct_ready, 0);
                @(negedge clk);
                abort = 1'b0; ct_valid = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_pt_valid", pt_valid, 0);
                check("abort_done", done, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                aborted = 1;
            end else begin
                if (v.stall && !stalled && pt_valid) begin
                    stalled = 1; stall = 5;
                    hold_pt = pt_data; hold_vc = core_vc;
                end
                ct_valid = (ci <= n) && (!v.thr || $urandom_range(3) != 0);
                ct_data  = (ci <= n) ? ct[ci] : '0;
                if (stall > 0) pt_ready = 1'b0;
                else pt_ready = !v.thr || $urandom_range(2) != 0;
                #1;
                if (stall > 0) begin
                    check("stall_ct_ready", ct_ready, 0);
                    check("stall_pt_valid", pt_valid, 1);
                    check("stall_pt_data", pt_data, hold_pt);
                    check("stall_vc", core_vc, hold_vc);
                    stall--;
                end
                if (ct_valid && ct_ready) begin
                    if (ci == 0) c0chk = 1;
                    ci++;
                end
                if (pt_valid && pt_ready) begin
                    if (po < n) check("pt_data", pt_data, ep[po]);
                    else check("pt_extra", po, n);
                    po++;
                end
            end
        end
        ct_valid = 1'b0;
        pt_ready = 1'b0;
        if (!seen && !aborted) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: got no done, expected done within 4000");
        end
        if (seen) begin
            repeat (3) begin
                @(negedge clk);
                check("single_done", done, 0);
                check("idle_busy", busy, 0);
            end
        end
    endtask

    initial begin
        logic [CAP-1:0] f;
        tbl[0] = '{16'h1234, 64'hDEAD_BEEF_CAFE_0F0F, 4, 1, 0, 0, 0,
                   16'h1D3B, 0};
        tbl[1] = '{16'hFFFF, 64'h0123_4567_89AB_0000, 3, 2, 0, 1, 0,
                   16'hFFFF, 0};
        tbl[2] = '{16'h0001, 64'h1111_2222_3333_0100, 255, 7, 0, 0, 0,
                   16'h0101, 0};
        tbl[3] = '{16'h0001, 64'h1111_2222_3333_0100, 255, 7, 1, 0, 0,
                   16'h0101, 1};
        tbl[4] = '{16'h5555, 64'h0000_0000_0000_AAAA, 5, 3, 0, 0, 2,
                   16'hFFFF, 0};
        tbl[5] = '{16'h0F0F, 64'hFFFF_0000_FFFF_0F0F, 2, 4, 0, 0, 0,
                   16'h0000, 0};
        tbl[6] = '{16'hC3C3, 64'h0000_1111_0000_3C3C, 9, 5, 1, 0, 0,
                   16'hFFFF, 0};
        last_fin = '0;

        #2 error = 1'b0;
        #2;
        check("rst_ct_ready", ct_ready, 0);
        check("rst_pt_valid", pt_valid, 0);
        check("rst_pt_data", pt_data, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fin_vc", fin_vc, 0);
        check("rst_vc", core_vc, 0);
        check("rst_prev", core_prev, 0);
        check("rst_key", core_key, 0);
        check("rst_tag", core_tag, 0);
        @(negedge clk);
        error = 1'b1;

        // Init beat only, nblk=0.
        @(negedge clk);
        start = 1'b1; tag = 16'hA5A5; key_i = 64'h0000_0000_0000_0F0F;
        nblk = '0;
        @(negedge clk);
        start = 1'b0;
        check("init_ct_ready", ct_ready, 1);
        check("init_core_rst_n", core_rst_n, 0);
        check("init_busy", busy, 1);
        ct_valid = 1'b1; ct_data = 34'h1_2345_6789;
        @(negedge clk);
        ct_valid = 1'b0;
        check("c0_vc", core_vc, 16'hAAAA);
        check("c0_prev", core_prev, 34'h1_2345_6789);
        check("c0_done_early", done, 0);
        check("done_ct_ready", ct_ready, 0);
        check("done_core_rst_n", core_rst_n, 0);
        @(negedge clk);
        check("c0_done", done, 1);
        check("c0_fin_vc", fin_vc, 16'hAAAA);
        check("c0_idle", busy, 0);
        @(negedge clk);
        check("c0_done_once", done, 0);

        for (int k = 0; k < 7; k++) begin
            run_msg(tbl[k], f);
            if (tbl[k].cmp_prev) check("throttled_fin", f, last_fin);
            if (tbl[k].abort_at == 0) last_fin = f;
        end

        // Reset mid-message, start held while in reset.
        @(negedge clk);
        start = 1'b1; tag = 16'h9999; key_i = 64'h5; nblk = 8'd20;
        @(negedge clk);
        start = 1'b0; ct_valid = 1'b1; pt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ct_data = gen(9, i);
            @(negedge clk);
        end
        check("pre_err_busy", busy, 1);
        #2 error = 1'b0;
        #1;
        check("err_busy", busy, 0);
        check("err_pt_valid", pt_valid, 0);
        check("err_pt_data", pt_data, 0);
        check("err_ct_ready", ct_ready, 0);
        check("err_core_rst_n", core_rst_n, 0);
        check("err_vc", core_vc, 0);
        check("err_prev", core_prev, 0);
        check("err_key", core_key, 0);
        check("err_fin_vc", fin_vc, 0);
        ct_valid = 1'b0; pt_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_start_ignored", busy, 0);
        error = 1'b1;
        @(negedge clk);
        check("post_err_idle", busy, 0);
        run_msg(tbl[5], f);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ape_dec_ctrl.md
APE_DEC_CTRL -- requirements
Module: ape_dec_ctrl

Interface
REQ-001 The block SHALL have parameter RATE, default 34: ciphertext/plaintext beat width in bits.
REQ-002 The block SHALL have parameter CAP, default 16: capacity/Vc width in bits.
REQ-003 The block SHALL have parameter CW, default 8: block-count width in bits.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 error  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a message; honoured only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the current message.
REQ-008 key_i  in  64  key; sampled on an accepted start.
REQ-009 tag  in  CAP  message tag; sampled on an accepted start.
REQ-010 nblk  in  CW  number of data beats following the init beat; sampled on an accepted start.
REQ-011 ct_valid / ct_ready  in / out  1 / 1  ciphertext handshake.
REQ-012 ct_data  in  RATE  ciphertext beat.
REQ-013 pt_valid / pt_ready  out / in  1 / 1  plaintext handshake.
REQ-014 pt_data  out  RATE  plaintext beat (registered).
REQ-015 core_rst_n  out  1  drives the decryption core's reset; low holds the core in INIT.
REQ-016 core_key / core_tag / core_ctext  out  64 / CAP / RATE  core inputs: latched key, latched tag, ct_data passthrough.
REQ-017 core_vc / core_prev  out  CAP / RATE  feedback registers vc_reg and prev_reg.
REQ-018 core_dout / core_vc_l / core_prev_l  in  RATE / CAP / RATE  core combinational results.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse on message completion.
REQ-021 fin_vc  out  CAP  final vc_reg value, valid from the done cycle until the next accepted start.

Function
REQ-022 The FSM SHALL have states IDLE, INIT, RUN and DONE.
REQ-023 IDLE: start=1 SHALL latch key_i, tag and nblk, load cnt with nblk, and go to INIT.
REQ-024 INIT: core_rst_n=0 and ct_ready=1; an accepted beat (C0) SHALL load vc_reg<=core_vc_l (=tag^key[15:0]) and prev_reg<=core_prev_l (=C0).
REQ-025 After C0 is accepted, the FSM SHALL go to RUN, or to DONE if cnt=0.
REQ-026 RUN: core_rst_n=1 and ct_ready = !pt_valid || pt_ready (single-entry output buffer, full throughput).
REQ-027 Each accepted RUN beat SHALL load pt_data<=core_dout, set pt_valid=1, update vc_reg<=core_vc_l and prev_reg<=ct_data, and decrement cnt.
REQ-028 The accepted RUN beat that decrements cnt from 1 to 0 SHALL move the FSM to DONE.
REQ-029 pt_valid SHALL clear on a pt_ready handshake unless a new beat is loaded in the same cycle; it SHALL never drop while pt_ready=0.
REQ-030 vc_reg and prev_reg SHALL change only on accepted beats; stalls on either side SHALL hold them.
REQ-031 DONE: the FSM SHALL wait until pt_valid=0, then assert done for one cycle, load fin_vc<=vc_reg, and return to IDLE.
REQ-032 ct_ready SHALL be 0 in IDLE and DONE; start outside IDLE SHALL be ignored.
REQ-033 abort=1 in any state SHALL go to IDLE next cycle, clear pt_valid and cnt, and SHALL NOT pulse done; abort takes priority over a simultaneous handshake.
REQ-034 core_rst_n SHALL be 0 in IDLE, INIT and DONE.

Reset
REQ-035 With error=0, outputs SHALL be: state IDLE, ct_ready=0, pt_valid=0, pt_data=0, core_rst_n=0, busy=0, done=0, fin_vc=0, vc_reg=0, prev_reg=0, cnt=0, latched key/tag=0.
REQ-036 Reset assertion mid-message SHALL discard all state immediately; the first start after error rises SHALL begin a clean message.

Verification
REQ-037 Init beat: tag=16'hA5A5, key[15:0]=16'h0F0F, nblk=0, C0=34'h1_2345_6789 -> vc_reg=16'hAAAA, prev_reg=34'h1_2345_6789, done pulse 2 cycles after C0 is accepted, fin_vc=16'hAAAA.
REQ-038 nblk=4, continuous valid, pt_ready=1 -> 4 pt beats on consecutive cycles, each matching the reference-model APE decryption; exactly one done pulse.
REQ-039 nblk=3, pt_ready held 0 for 5 cycles after the first pt beat -> ct_ready=0 while the buffer is full; pt_data and vc_reg stable; no beat lost or duplicated.
REQ-040 Random ct_valid/pt_ready throttling over nblk=255 -> output stream identical to the unthrottled run; fin_vc identical.
REQ-041 abort asserted in RUN after 2 of 5 beats -> next cycle IDLE, pt_valid=0, no done; a following message decrypts correctly.
REQ-042 error pulsed low in RUN -> all outputs at reset values asynchronously; start ignored while error=0.
